cell_comm_packet_arbiter: RTL

// - Packet-mode round-robin arbiter merging NUM_BPMS per-BPM AXI-stream FA packet sources onto one CW or CCW link TX stream.
// - Grant is held from first beat to tlast, so packets never interleave.
// - Drains sources while the link is down, and truncates runaway packets.
// - One instance per ring direction, between the per-BPM packet builders and the link TX.

---
 rtl/cell_comm_packet_arbiter_pkg.sv | 23 ++
 rtl/cell_comm_packet_arbiter_if.sv | 29 ++
 rtl/cell_comm_packet_arbiter_rr_pick.sv | 30 +++
 rtl/cell_comm_packet_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cell_comm_packet_arbiter_pkg.sv
// rtl/cell_comm_packet_arbiter_pkg.sv - shared state encoding, defaults and saturating increment
package cell_comm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } arb_state_e;

  localparam int CELL_COMM_MAX_PKT_WORDS = 16;
  localparam int CELL_COMM_SAT_W         = 64;

  // Increment the low w bits of v, holding at all-ones instead of wrapping.
  function automatic logic [CELL_COMM_SAT_W-1:0] sat_inc(
    input logic [CELL_COMM_SAT_W-1:0] v,
    input int unsigned                w
  );
    logic [CELL_COMM_SAT_W-1:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v & mask) == mask) ? v : (v + 64'd1);
  endfunction

endpackage

// File: rtl/cell_comm_packet_arbiter_if.sv
// rtl/cell_comm_packet_arbiter_if.sv - per-source and merged TX streams of the packet arbiter
interface cell_comm_packet_arbiter_if #(
  parameter int NUM_BPMS   = 2,
  parameter int DATA_WIDTH = 32
) ();

  logic [NUM_BPMS-1:0]            srcTvalid;
  logic [NUM_BPMS-1:0]            srcTlast;
  logic [NUM_BPMS*DATA_WIDTH-1:0] srcTdata;
  logic [NUM_BPMS-1:0]            srcTready;
  logic [NUM_BPMS-1:0]            srcSuppress;
  logic                           txTvalid;
  logic                           txTlast;
  logic [DATA_WIDTH-1:0]          txTdata;
  logic                           txTready;

  // Arbiter side: consumes the sources, drives the link TX stream.
  modport slave (
    input  srcTvalid, srcTlast, srcTdata, srcSuppress, txTready,
    output srcTready, txTvalid, txTlast, txTdata
  );

  // Environment side: packet builders and link TX.
  modport master (
    output srcTvalid, srcTlast, srcTdata, srcSuppress, txTready,
    input  srcTready, txTvalid, txTlast, txTdata
  );

endinterface

// File: rtl/cell_comm_packet_arbiter_rr_pick.sv
// rtl/cell_comm_packet_arbiter_rr_pick.sv - combinational round-robin picker starting after the last grant
module cell_comm_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_req_o
);

  // Scan distances 1..N from the last grant; distance N wraps back to the last grant itself.
  always_comb begin
    logic found;
    found   = 1'b0;
    grant_o = last_grant_i;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req_i[j] &&
            (((int'(last_grant_i) + k) % N) == j)) begin
          grant_o = IDX_W'(j);
          found   = 1'b1;
        end
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/cell_comm_packet_arbiter.sv
// rtl/cell_comm_packet_arbiter.sv - packet-mode round-robin merge of per-BPM streams onto one link TX
// Per-source packet counters exist only when CELL_COMM_ARB_STATS_EN is defined.
module cell_comm_packet_arbiter
  import cell_comm_pkg::*;
#(
  parameter int NUM_BPMS      = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_PKT_WORDS = CELL_COMM_MAX_PKT_WORDS,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            axisUserClk,
  input  logic                            axisUserReset,
  input  logic                            channelUp,
  cell_comm_packet_arbiter_if.slave       axis,
  output logic [$clog2(NUM_BPMS):0]       grantIdx,
  output logic                            busy,
  output logic [CNT_WIDTH-1:0]            dropCount,
  output logic [CNT_WIDTH-1:0]            truncCount,
  output logic [NUM_BPMS*CNT_WIDTH-1:0]   pktCount
);

  localparam int IDX_W = $clog2(NUM_BPMS) + 1;
  localparam int WC_W  = $clog2(MAX_PKT_WORDS) + 1;

  arb_state_e            state_q;
  logic [IDX_W-1:0]      grant_q;
  logic [WC_W-1:0]       word_cnt_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;
  logic [CNT_WIDTH-1:0]  trunc_cnt_q;

  logic [NUM_BPMS-1:0]   req;
  logic [IDX_W-1:0]      pick_grant;
  logic                  any_req;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_BPMS-1:0]   sel_onehot;
  logic                  forced_last;
  logic                  tx_hs;

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CELL_COMM_SAT_W-1:0] ext;
    ext                = '0;
    ext[CNT_WIDTH-1:0] = v;
    ext                = sat_inc(ext, CNT_WIDTH);
    return ext[CNT_WIDTH-1:0];
  endfunction

  assign req = axis.srcTvalid & ~axis.srcSuppress;

  cell_comm_rr_pick #(
    .N     (NUM_BPMS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (grant_q),
    .grant_o      (pick_grant),
    .any_req_o    (any_req)
  );

  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_BPMS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid     = axis.srcTvalid[i];
        sel_last      = axis.srcTlast[i];
        sel_data      = axis.srcTdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign forced_last = (word_cnt_q == WC_W'(MAX_PKT_WORDS - 1));
  assign tx_hs       = (state_q == ST_PASS) && sel_valid && axis.txTready;

  // Only the granted source ever sees ready; outside PASS the link side stays idle.
  always_comb begin
    axis.txTvalid  = 1'b0;
    axis.txTlast   = 1'b0;
    axis.txTdata   = '0;
    axis.srcTready = '0;
    case (state_q)
      ST_PASS: begin
        axis.txTvalid  = sel_valid;
        axis.txTlast   = sel_last | forced_last;
        axis.txTdata   = sel_data;
        axis.srcTready = sel_onehot & {NUM_BPMS{axis.txTready}};
      end
      ST_DROP: begin
        axis.srcTready = sel_onehot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge axisUserClk) begin
    if (axisUserReset) begin
      state_q     <= ST_IDLE;
      grant_q     <= IDX_W'(NUM_BPMS - 1);
      word_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q    <= pick_grant;
            word_cnt_q <= '0;
            if (channelUp) begin
              state_q <= ST_PASS;
            end else begin
              state_q    <= ST_DROP;
              drop_cnt_q <= cnt_inc(drop_cnt_q);
            end
          end
        end
        ST_PASS: begin
          // A genuine tlast wins over both truncation and a falling link.
          if (tx_hs) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (sel_last) begin
              state_q <= ST_IDLE;
            end else if (forced_last) begin
              state_q     <= ST_DROP;
              trunc_cnt_q <= cnt_inc(trunc_cnt_q);
            end else if (!channelUp) begin
              state_q    <= ST_DROP;
              drop_cnt_q <= cnt_inc(drop_cnt_q);
            end
          end else if (!channelUp) begin
            state_q    <= ST_DROP;
            drop_cnt_q <= cnt_inc(drop_cnt_q);
          end
        end
        ST_DROP: begin
          if (sel_valid && sel_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign grantIdx   = grant_q;
  assign dropCount  = drop_cnt_q;
  assign truncCount = trunc_cnt_q;

`ifdef CELL_COMM_ARB_STATS_EN
  logic                 pkt_done;
  logic [CNT_WIDTH-1:0] pkt_cnt_q [NUM_BPMS];

  assign pkt_done = tx_hs && sel_last;

  always_ff @(posedge axisUserClk) begin
    if (axisUserReset) begin
      for (int i = 0; i < NUM_BPMS; i++) pkt_cnt_q[i] <= '0;
    end else if (pkt_done) begin
      for (int i = 0; i < NUM_BPMS; i++) begin
        if (sel_onehot[i]) pkt_cnt_q[i] <= cnt_inc(pkt_cnt_q[i]);
      end
    end
  end

  always_comb begin
    pktCount = '0;
    for (int i = 0; i < NUM_BPMS; i++) pktCount[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[i];
  end
`else
  assign pktCount = '0;
`endif

endmodule
